// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the five-stage pipeline: RAW hazard detection,
// taken-branch bubbles and an SRAM-wait freeze FSM with timeout and stall counter.
module pipeline_hazard_controller #(
  parameter int FORWARD_EN   = 0,
  parameter int SRAM_TIMEOUT = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           src1,
  input  logic [3:0]           src2,
  input  logic                 srcValid,
  input  logic                 twoSrc,
  input  logic [3:0]           exeDest,
  input  logic                 exeWbEn,
  input  logic                 exeMemRead,
  input  logic [3:0]           memDest,
  input  logic                 memWbEn,
  input  logic                 branchTaken,
  input  logic                 memReq,
  input  logic                 sramReady,
  output logic                 freezeIF,
  output logic                 flushIF2ID,
  output logic                 flushID2EXE,
  output logic                 stallPipe,
  output logic                 sramTimeout,
  output logic [CNT_WIDTH-1:0] stallCount
);

  localparam int WW = (SRAM_TIMEOUT < 1) ? 1 : $clog2(SRAM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(SRAM_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_TIMEOUT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] waitCnt, wait_nxt;
  logic          exe_match, mem_match, hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      waitCnt     <= '0;
      sramTimeout <= 1'b0;
      stallCount  <= '0;
    end else begin
      state   <= state_nxt;
      waitCnt <= wait_nxt;
      if (state_nxt == S_TIMEOUT)
        sramTimeout <= 1'b1;
      if ((freezeIF || stallPipe) && (stallCount != '1))
        stallCount <= stallCount + CNT_WIDTH'(1);
    end
  end

  // Ready is checked before the timeout compare so a late ready still wins.
  always_comb begin
    state_nxt = state;
    wait_nxt  = waitCnt;
    stallPipe = 1'b0;
    case (state)
      S_RUN: begin
        if (memReq && !sramReady) begin
          stallPipe = 1'b1;
          state_nxt = S_WAIT;
          wait_nxt  = WW'(1);
        end
      end
      S_WAIT: begin
        if (sramReady) begin
          state_nxt = S_RUN;
          wait_nxt  = '0;
        end else begin
          stallPipe = 1'b1;
          if (waitCnt == TO_VAL)
            state_nxt = S_TIMEOUT;
          else
            wait_nxt = waitCnt + WW'(1);
        end
      end
      S_TIMEOUT: stallPipe = 1'b1;
      default:   state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    exe_match = exeWbEn & ((srcValid & (src1 == exeDest)) | (twoSrc & (src2 == exeDest)));
    mem_match = memWbEn & ((srcValid & (src1 == memDest)) | (twoSrc & (src2 == memDest)));
    if (FORWARD_EN != 0)
      hazard = exeMemRead & exe_match;
    else
      hazard = exe_match | mem_match;
  end

  always_comb begin
    freezeIF    = 1'b0;
    flushIF2ID  = 1'b0;
    flushID2EXE = 1'b0;
    if (stallPipe) begin
      freezeIF = 1'b1;
    end else if (branchTaken) begin
      flushIF2ID  = 1'b1;
      flushID2EXE = 1'b1;
    end else if (hazard) begin
      freezeIF    = 1'b1;
      flushID2EXE = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (no forwarding / forwarding
// with short timeout and narrow counter) checked against a behavioural model.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, srcValid, twoSrc, exeWbEn, exeMemRead, memWbEn;
  logic       branchTaken, memReq, sramReady;
  logic [3:0] src1, src2, exeDest, memDest;

  logic        freezeIF0, flushIF2ID0, flushID2EXE0, stallPipe0, sramTimeout0;
  logic [15:0] stallCount0;
  logic        freezeIF1, flushIF2ID1, flushID2EXE1, stallPipe1, sramTimeout1;
  logic [3:0]  stallCount1;

  pipeline_hazard_controller #(.FORWARD_EN(0), .SRAM_TIMEOUT(15), .CNT_WIDTH(16)) d0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .srcValid(srcValid), .twoSrc(twoSrc),
    .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead), .memDest(memDest),
    .memWbEn(memWbEn), .branchTaken(branchTaken), .memReq(memReq), .sramReady(sramReady),
    .freezeIF(freezeIF0), .flushIF2ID(flushIF2ID0), .flushID2EXE(flushID2EXE0),
    .stallPipe(stallPipe0), .sramTimeout(sramTimeout0), .stallCount(stallCount0));

  pipeline_hazard_controller #(.FORWARD_EN(1), .SRAM_TIMEOUT(3), .CNT_WIDTH(4)) d1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .srcValid(srcValid), .twoSrc(twoSrc),
    .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead), .memDest(memDest),
    .memWbEn(memWbEn), .branchTaken(branchTaken), .memReq(memReq), .sramReady(sramReady),
    .freezeIF(freezeIF1), .flushIF2ID(flushIF2ID1), .flushID2EXE(flushID2EXE1),
    .stallPipe(stallPipe1), .sramTimeout(sramTimeout1), .stallCount(stallCount1));

  int nchk = 0;
  int nfail = 0;

  // Reference model: cycles spent waiting on SRAM (0 = not waiting), dead = timed out.
  int TOv[2]  = '{15, 3};
  int CMAX[2] = '{65535, 15};
  bit FE[2]   = '{1'b0, 1'b1};
  int waited[2];
  bit dead[2];
  int cnt[2];

  function automatic bit mt(logic [3:0] d);
    return (srcValid && src1 == d) || (twoSrc && src2 == d);
  endfunction

  function automatic bit haz_m(int i);
    if (FE[i]) return exeMemRead && exeWbEn && mt(exeDest);
    return (exeWbEn && mt(exeDest)) || (memWbEn && mt(memDest));
  endfunction

  function automatic bit stall_m(int i);
    return dead[i] || (!sramReady && (waited[i] > 0 || memReq));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; src1 = 0; src2 = 0; srcValid = 0; twoSrc = 0; exeDest = 0; exeWbEn = 0;
    exeMemRead = 0; memDest = 0; memWbEn = 0; branchTaken = 0; memReq = 0; sramReady = 1;
  endtask

  // Check every output of both instances against the model, then clock once.
  task automatic cycle();
    bit s, h, b, f;
    #1;
    for (int i = 0; i < 2; i++) begin
      s = stall_m(i); h = haz_m(i); b = branchTaken;
      chk($sformatf("d%0d.stallPipe", i), i ? stallPipe1 : stallPipe0, s);
      chk($sformatf("d%0d.freezeIF", i), i ? freezeIF1 : freezeIF0, s | (!b & h));
      chk($sformatf("d%0d.flushIF2ID", i), i ? flushIF2ID1 : flushIF2ID0, !s & b);
      chk($sformatf("d%0d.flushID2EXE", i), i ? flushID2EXE1 : flushID2EXE0, !s & (b | h));
      chk($sformatf("d%0d.sramTimeout", i), i ? sramTimeout1 : sramTimeout0, dead[i]);
      chk($sformatf("d%0d.stallCount", i), i ? {28'b0, stallCount1} : {16'b0, stallCount0}, cnt[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      s = stall_m(i);
      f = s | (!branchTaken & haz_m(i));
      if (rst) begin
        waited[i] = 0; dead[i] = 0; cnt[i] = 0;
      end else begin
        if (f && cnt[i] < CMAX[i]) cnt[i]++;
        if (!dead[i]) begin
          if (waited[i] == 0) begin
            if (memReq && !sramReady) waited[i] = 1;
          end else if (sramReady) waited[i] = 0;
          else if (waited[i] == TOv[i]) dead[i] = 1;
          else waited[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  int sc_before, nstall;

  initial begin
    for (int i = 0; i < 2; i++) begin waited[i] = 0; dead[i] = 0; cnt[i] = 0; end
    @(posedge clk); #1;
    do_reset();
    #1;
    chk("reset.stallCount0", stallCount0, 0);
    chk("reset.sramTimeout1", sramTimeout1, 0);
    chk("reset.freezeIF0", freezeIF0, 0);
    cycle();

    // RAW without forwarding
    idle(); src1 = 3; srcValid = 1; exeDest = 3; exeWbEn = 1; #1;
    chk("raw_exe.freezeIF0", freezeIF0, 1);
    chk("raw_exe.flushID2EXE0", flushID2EXE0, 1);
    chk("raw_exe.freezeIF1", freezeIF1, 0);
    cycle();
    exeWbEn = 0; memDest = 3; memWbEn = 1; #1;
    chk("raw_mem.freezeIF0", freezeIF0, 1);
    cycle();
    idle(); srcValid = 1; src1 = 0; src2 = 3; twoSrc = 0; exeDest = 3; exeWbEn = 1; #1;
    chk("raw_twoSrc0.freezeIF0", freezeIF0, 0);
    cycle();

    // Load-use with forwarding
    idle(); exeMemRead = 1; exeWbEn = 1; exeDest = 5; src2 = 5; twoSrc = 1; #1;
    chk("loaduse.freezeIF1", freezeIF1, 1);
    chk("loaduse.flushID2EXE1", flushID2EXE1, 1);
    cycle();
    exeMemRead = 0; #1;
    chk("noload.freezeIF1", freezeIF1, 0);
    chk("noload.freezeIF0", freezeIF0, 1);
    cycle();
    idle(); memDest = 5; memWbEn = 1; src2 = 5; twoSrc = 1; #1;
    chk("memmatch.freezeIF1", freezeIF1, 0);
    cycle();

    // Branch beats hazard; counter untouched
    idle(); exeMemRead = 1; exeWbEn = 1; exeDest = 5; src2 = 5; twoSrc = 1; branchTaken = 1; #1;
    sc_before = stallCount0;
    chk("branch.freezeIF1", freezeIF1, 0);
    chk("branch.flushIF2ID1", flushIF2ID1, 1);
    chk("branch.flushID2EXE1", flushID2EXE1, 1);
    chk("branch.freezeIF0", freezeIF0, 0);
    cycle();
    chk("branch.stallCount0", stallCount0, sc_before);

    // SRAM wait of four cycles
    do_reset();
    nstall = 0;
    memReq = 1; sramReady = 0;
    for (int k = 0; k < 4; k++) begin #1; nstall += int'(stallPipe0); cycle(); end
    sramReady = 1; #1; nstall += int'(stallPipe0); cycle();
    memReq = 0; #1;
    chk("wait4.stallcycles", nstall, 4);
    chk("wait4.stallCount0", stallCount0, 4);
    chk("wait4.stallPipe0_after", stallPipe0, 0);
    cycle();

    // Timeout on the short-timeout instance, then reset recovery
    do_reset();
    memReq = 1; sramReady = 0;
    for (int j = 0; j < 6; j++) begin
      #1; chk($sformatf("timeout.cyc%0d", j), sramTimeout1, (j >= 4) ? 1 : 0);
      cycle();
    end
    memReq = 0; #1;
    chk("timeout.sticky", sramTimeout1, 1);
    chk("timeout.stallPipe1", stallPipe1, 1);
    cycle();
    do_reset(); #1;
    chk("rst.sramTimeout1", sramTimeout1, 0);
    chk("rst.stallCount1", stallCount1, 0);
    chk("rst.stallPipe1", stallPipe1, 0);
    cycle();

    // Counter saturation
    do_reset();
    exeMemRead = 1; exeWbEn = 1; exeDest = 7; src1 = 7; srcValid = 1;
    for (int j = 0; j < 20; j++) cycle();
    #1;
    chk("sat.stallCount1", stallCount1, 15);
    chk("sat.stallCount0", stallCount0, 20);
    cycle();

    // Randomised traffic
    do_reset();
    for (int j = 0; j < 500; j++) begin
      rst         = ($urandom_range(0, 59) == 0);
      src1        = 4'($urandom_range(0, 3));
      src2        = 4'($urandom_range(0, 3));
      exeDest     = 4'($urandom_range(0, 3));
      memDest     = 4'($urandom_range(0, 3));
      srcValid    = 1'($urandom);
      twoSrc      = 1'($urandom);
      exeWbEn     = 1'($urandom);
      exeMemRead  = 1'($urandom);
      memWbEn     = 1'($urandom);
      branchTaken = ($urandom_range(0, 5) == 0);
      memReq      = ($urandom_range(0, 3) == 0);
      sramReady   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
